// File: rtl/axi_ram_fill.sv
// AXI4 write-only fill sequencer: writes a constant or incrementing pattern over a
// word-aligned region using INCR bursts that stay inside 4 KB pages.
module axi_ram_fill #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 16,
    parameter int STRB_WIDTH    = DATA_WIDTH / 8,
    parameter int ID_WIDTH      = 8,
    parameter int AXI_ID        = 0,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] word_count,
    input  logic [DATA_WIDTH-1:0] pattern,
    input  logic                  pattern_incr,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready
);

    localparam int SIZE = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] AW     = 3'd1;
    localparam logic [2:0] W      = 3'd2;
    localparam logic [2:0] B      = 3'd3;
    localparam logic [2:0] FINISH = 3'd4;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] remaining;
    logic [8:0]            beats;
    logic [7:0]            beat_cnt;
    logic                  incr;
    logic                  unused_bid;

    // Smallest of words left, the burst cap and the words left in this 4 KB page.
    function automatic logic [8:0] calc_beats(input logic [ADDR_WIDTH-1:0] a,
                                              input logic [ADDR_WIDTH-1:0] rem);
        logic [31:0] lim;
        logic [31:0] room;
        logic [31:0] r;
        room = (32'd4096 - {20'd0, a[11:0]}) >> SIZE;
        r    = 32'(rem);
        lim  = 32'(MAX_BURST_LEN);
        if (room < lim) lim = room;
        if (r < lim) lim = r;
        return lim[8:0];
    endfunction

    logic [ADDR_WIDTH-1:0] start_addr;
    logic [8:0]            start_beats;
    logic [8:0]            next_beats;

    assign start_addr  = base_addr & ALIGN_MASK;
    assign start_beats = calc_beats(start_addr, word_count);
    assign next_beats  = calc_beats(addr, remaining);

    assign busy          = (state == AW) || (state == W) || (state == B);
    assign m_axi_awid    = ID_WIDTH'(AXI_ID);
    assign m_axi_awsize  = 3'(SIZE);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wstrb   = '1;
    assign unused_bid    = ^m_axi_bid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr          <= '0;
            remaining     <= '0;
            beats         <= '0;
            beat_cnt      <= '0;
            incr          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awlen   <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wlast   <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        err         <= 1'b0;
                        incr        <= pattern_incr;
                        m_axi_wdata <= pattern;
                        if (word_count != '0) begin
                            addr          <= start_addr;
                            remaining     <= word_count;
                            beats         <= start_beats;
                            m_axi_awaddr  <= start_addr;
                            m_axi_awlen   <= 8'(start_beats - 9'd1);
                            m_axi_awvalid <= 1'b1;
                            state         <= AW;
                        end else begin
                            state <= FINISH;
                        end
                    end
                end
                AW: begin
                    if (m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        m_axi_wvalid  <= 1'b1;
                        m_axi_wlast   <= (beats == 9'd1);
                        beat_cnt      <= 8'(beats - 9'd1);
                        state         <= W;
                    end
                end
                W: begin
                    if (m_axi_wready) begin
                        if (incr) m_axi_wdata <= m_axi_wdata + DATA_WIDTH'(1);
                        if (beat_cnt == 8'd0) begin
                            m_axi_wvalid <= 1'b0;
                            m_axi_wlast  <= 1'b0;
                            m_axi_bready <= 1'b1;
                            addr         <= addr + ADDR_WIDTH'(32'(beats) << SIZE);
                            remaining    <= remaining - ADDR_WIDTH'(beats);
                            state        <= B;
                        end else begin
                            beat_cnt    <= beat_cnt - 8'd1;
                            m_axi_wlast <= (beat_cnt == 8'd1);
                        end
                    end
                end
                B: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        if (m_axi_bresp != 2'b00) err <= 1'b1;
                        if (remaining == '0) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            beats         <= next_beats;
                            m_axi_awaddr  <= addr;
                            m_axi_awlen   <= 8'(next_beats - 9'd1);
                            m_axi_awvalid <= 1'b1;
                            state         <= AW;
                        end
                    end
                end
                FINISH: begin
                    // A normal fill raised done on the B handshake; a zero-length fill raises it here.
                    done  <= !done;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ram_fill.sv
// Directed bench for axi_ram_fill: a RAM-backed AXI slave model plus a table of fills
// and hand-written zero-count and reset sequences.
module tb_axi_ram_fill;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] word_count;
    logic [31:0] pattern;
    logic        pattern_incr;
    logic        busy, done, err;
    logic [7:0]  awid;
    logic [15:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [7:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    axi_ram_fill dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .pattern(pattern), .pattern_incr(pattern_incr),
        .busy(busy), .done(done), .err(err),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
        .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awlock(awlock),
        .m_axi_awcache(awcache), .m_axi_awprot(awprot),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model state
    logic [31:0] mem [0:16383];
    logic [23:0] aw_log [$];
    logic        bp_mode = 1'b0;
    int          err_burst = -1;
    int          viol = 0;
    logic [15:0] cur_addr;
    logic [7:0]  cur_len;
    logic [7:0]  w_beat;
    logic        aw_open;
    logic        p_aw_stall, p_w_stall;
    logic [15:0] p_awaddr;
    logic [7:0]  p_awlen;
    logic [31:0] p_wdata;
    logic        p_wlast;

    assign bid = 8'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awready    <= 1'b0;
            wready     <= 1'b0;
            bvalid     <= 1'b0;
            bresp      <= 2'b00;
            cur_addr   <= '0;
            cur_len    <= '0;
            w_beat     <= '0;
            aw_open    <= 1'b0;
            p_aw_stall <= 1'b0;
            p_w_stall  <= 1'b0;
        end else begin
            awready <= bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            wready  <= bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (start) aw_log.delete();
            if (p_aw_stall && (awvalid !== 1'b1 || awaddr !== p_awaddr || awlen !== p_awlen))
                viol <= viol + 1;
            if (p_w_stall && (wvalid !== 1'b1 || wdata !== p_wdata || wlast !== p_wlast))
                viol <= viol + 1;
            if (wvalid && !aw_open) viol <= viol + 1;
            if (wstrb !== 4'hF || awsize !== 3'd2 || awburst !== 2'b01 || awid !== 8'h00 ||
                awcache !== 4'b0011 || awlock !== 1'b0 || awprot !== 3'b000)
                viol <= viol + 1;
            p_aw_stall <= awvalid && !awready;
            p_w_stall  <= wvalid && !wready;
            p_awaddr   <= awaddr;
            p_awlen    <= awlen;
            p_wdata    <= wdata;
            p_wlast    <= wlast;
            if (awvalid && awready) begin
                aw_log.push_back({awaddr, awlen});
                cur_addr <= awaddr;
                cur_len  <= awlen;
                w_beat   <= 8'd0;
                aw_open  <= 1'b1;
            end
            if (wvalid && wready) begin
                mem[cur_addr[15:2]] <= wdata;
                cur_addr <= cur_addr + 16'd4;
                w_beat   <= w_beat + 8'd1;
                if (wlast !== (w_beat == cur_len)) viol <= viol + 1;
                if (wlast) begin
                    aw_open <= 1'b0;
                    bvalid  <= 1'b1;
                    bresp   <= (aw_log.size() - 1 == err_burst) ? 2'b10 : 2'b00;
                end
            end
            if (bvalid && bready) bvalid <= 1'b0;
        end
    end

    int vec_cnt = 0;
    int miss_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0]       base;
        logic [15:0]       count;
        logic [31:0]       pat;
        logic              incr;
        logic              bp;
        int                err_burst;
        logic              exp_err;
        int                nb;
        logic [2:0][23:0]  bursts;
    } vec_t;

    function automatic logic [23:0] bu(input logic [15:0] a, input logic [7:0] l);
        return {a, l};
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_out"}, {busy, done, err, awvalid, wvalid, wlast, bready},  7'b0);
        check({tag, "_payload"}, {awaddr, awlen, wdata}, 56'h0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int t;
        int bad;
        logic [15:0] a;
        logic [15:0] ab;
        bp_mode      = v.bp;
        err_burst    = v.err_burst;
        base_addr    = v.base;
        word_count   = v.count;
        pattern      = v.pat;
        pattern_incr = v.incr;
        start = 1'b1;
        step();
        start = 1'b0;
        check($sformatf("v%0d_busy_after_start", idx), busy, 1'b1);
        check($sformatf("v%0d_awvalid_after_start", idx), awvalid, 1'b1);
        t = 0;
        while (done !== 1'b1 && t < 3000) begin
            step();
            t++;
        end
        check($sformatf("v%0d_done_seen", idx), done, 1'b1);
        check($sformatf("v%0d_busy_at_done", idx), busy, 1'b0);
        check($sformatf("v%0d_err", idx), err, v.exp_err);
        check($sformatf("v%0d_nbursts", idx), aw_log.size(), v.nb);
        for (int j = 0; j < v.nb; j++)
            check($sformatf("v%0d_burst%0d", idx, j),
                  (j < aw_log.size()) ? aw_log[j] : 24'hxxxxxx, v.bursts[j]);
        bad = 0;
        ab = v.base & 16'hFFFC;
        for (int i = 0; i < int'(v.count); i++) begin
            a = ab + 16'(4 * i);
            if (mem[a[15:2]] !== (v.incr ? v.pat + 32'(i) : v.pat)) bad++;
        end
        check($sformatf("v%0d_ram_bad_words", idx), bad, 0);
        check($sformatf("v%0d_protocol_viol", idx), viol, 0);
        step();
        check($sformatf("v%0d_done_one_cycle", idx), done, 1'b0);
        bp_mode = 1'b0;
        step();
    endtask

    vec_t tv [8];

    initial begin
        tv[0] = '{base:16'h0000, count:16'd4, pat:32'hA5A5A5A5, incr:1'b0, bp:1'b0, err_burst:-1,
                  exp_err:1'b0, nb:1, bursts:{24'h0, 24'h0, bu(16'h0000, 8'd3)}};
        tv[1] = '{base:16'h0100, count:16'd40, pat:32'h0, incr:1'b1, bp:1'b0, err_burst:-1,
                  exp_err:1'b0, nb:3, bursts:{bu(16'h0180, 8'd7), bu(16'h0140, 8'd15), bu(16'h0100, 8'd15)}};
        tv[2] = '{base:16'h0FF8, count:16'd8, pat:32'h11110000, incr:1'b1, bp:1'b0, err_burst:-1,
                  exp_err:1'b0, nb:2, bursts:{24'h0, bu(16'h1000, 8'd5), bu(16'h0FF8, 8'd1)}};
        tv[3] = '{base:16'h0200, count:16'd20, pat:32'h0, incr:1'b1, bp:1'b1, err_burst:-1,
                  exp_err:1'b0, nb:2, bursts:{24'h0, bu(16'h0240, 8'd3), bu(16'h0200, 8'd15)}};
        tv[4] = '{base:16'h0400, count:16'd40, pat:32'hDEADBEEF, incr:1'b0, bp:1'b0, err_burst:1,
                  exp_err:1'b1, nb:3, bursts:{bu(16'h0480, 8'd7), bu(16'h0440, 8'd15), bu(16'h0400, 8'd15)}};
        tv[5] = '{base:16'h0600, count:16'd1, pat:32'h7, incr:1'b0, bp:1'b0, err_burst:-1,
                  exp_err:1'b0, nb:1, bursts:{24'h0, 24'h0, bu(16'h0600, 8'd0)}};
        tv[6] = '{base:16'hFFF2, count:16'd6, pat:32'd100, incr:1'b1, bp:1'b0, err_burst:-1,
                  exp_err:1'b0, nb:2, bursts:{24'h0, bu(16'h0000, 8'd1), bu(16'hFFF0, 8'd3)}};
        tv[7] = '{base:16'h2000, count:16'd16, pat:32'h5A5A0000, incr:1'b1, bp:1'b0, err_burst:-1,
                  exp_err:1'b0, nb:1, bursts:{24'h0, 24'h0, bu(16'h2000, 8'd15)}};

        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        word_count = '0;
        pattern = '0;
        pattern_incr = 1'b0;
        #23;
        check_idle_outputs("reset");
        step();
        rst_n = 1'b1;
        step();
        step();
        check_idle_outputs("post_reset");

        for (int k = 0; k < 8; k++) run_vec(tv[k], k);

        // Zero-length fill: done two cycles after start, no AXI traffic.
        base_addr  = 16'h0800;
        word_count = 16'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("zero_done_c1", done, 1'b0);
        check("zero_busy_c1", busy, 1'b0);
        check("zero_aw_c1", awvalid, 1'b0);
        step();
        check("zero_done_c2", done, 1'b1);
        check("zero_aw_c2", awvalid, 1'b0);
        step();
        check("zero_done_c3", done, 1'b0);
        check("zero_aw_c3", awvalid, 1'b0);

        // Asynchronous reset in the middle of a W burst.
        base_addr    = 16'h3000;
        word_count   = 16'd16;
        pattern      = 32'h1234;
        pattern_incr = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        begin
            int t;
            t = 0;
            while (wvalid !== 1'b1 && t < 50) begin
                step();
                t++;
            end
        end
        check("midw_wvalid_seen", wvalid, 1'b1);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midw_reset");
        step();
        check_idle_outputs("midw_reset_held");
        rst_n = 1'b1;
        step();
        check_idle_outputs("midw_released");
        run_vec(tv[7], 8);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/axi_ram_fill.md
# axi_ram_fill

AXI4 write-only initialization and scrub sequencer that fills a word-aligned region of an `axi_ram` with a constant or incrementing pattern. A single start pulse begins the fill. The block splits the region into INCR bursts that never cross a 4 KB boundary and never exceed MAX_BURST_LEN. It sits as an AXI master beside the normal requesters, and it is used at boot and for memory clear before reuse.

## Interface
- DATA_WIDTH, 32, AXI data width in bits (multiple of 8).
- ADDR_WIDTH, 16, AXI byte address width.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.
- ID_WIDTH, 8, AXI ID width.
- AXI_ID, 0, constant ID driven on awid.
- MAX_BURST_LEN, 16, maximum beats per burst (1..256).
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle start request; ignored while busy.
- base_addr  in  ADDR_WIDTH  region start byte address; low log2(STRB_WIDTH) bits are ignored (aligned down).
- word_count  in  ADDR_WIDTH  number of data words to write.
- pattern  in  DATA_WIDTH  first data word.
- pattern_incr  in  1  0: every word = pattern; 1: word i = pattern + i (mod 2^DATA_WIDTH).
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the fill completes.
- err  out  1  sticky; set on any bresp != OKAY; cleared by the next accepted start.
- m_axi_awid  out  ID_WIDTH  always AXI_ID.
- m_axi_awaddr  out  ADDR_WIDTH  burst start address.
- m_axi_awlen  out  8  beats-1.
- m_axi_awsize/awburst/awlock/awcache/awprot  out  3/2/1/4/3  constants: log2(STRB_WIDTH), INCR (2'b01), 0, 4'b0011, 0.
- m_axi_awvalid / m_axi_awready  out/in  1  AW handshake.
- m_axi_wdata  out  DATA_WIDTH  pattern word.
- m_axi_wstrb  out  STRB_WIDTH  all ones.
- m_axi_wlast  out  1  final beat of the burst.
- m_axi_wvalid / m_axi_wready  out/in  1  W handshake.
- m_axi_bid  in  ID_WIDTH  ignored.
- m_axi_bresp  in  2  checked for errors.
- m_axi_bvalid / m_axi_bready  in/out  1  B handshake.

## Operation
- States: IDLE, AW, W, B, DONE.
- IDLE: busy=0.
  - start with word_count != 0: latch the aligned base, remaining=word_count and data=pattern; clear err; go to AW.
  - start with word_count == 0: go to DONE with no AXI traffic.
- Burst sizing, computed on entry to AW: beats = min(remaining, MAX_BURST_LEN, (4096 - addr[11:0]) / STRB_WIDTH).
- AW: awvalid=1, with awaddr and awlen held stable until awready. On the handshake, go to W with beat_cnt=beats-1.
- W:
  - wvalid=1, and wdata is held stable until wready.
  - Each accepted beat: data increments by 1 if pattern_incr=1; beat_cnt decrements.
  - wlast=1 exactly when beat_cnt==0.
  - After the last beat: addr += beats*STRB_WIDTH (mod 2^ADDR_WIDTH), remaining -= beats; go to B.
- B: bready=1. On bvalid, set err if bresp != 2'b00. Then go to DONE if remaining==0, else to AW.
- DONE: done=1 for one cycle, busy=0; return to IDLE.
- One burst is outstanding at a time. wvalid is never asserted before the AW handshake of the same burst.
- Address wrap past 2^ADDR_WIDTH-1 continues at 0. The 4 KB rule still splits the burst at the wrap.
- rst_n low mid-operation:
  - State returns to IDLE immediately and any in-flight burst is abandoned.
  - The slave must be reset at the same time.

## Timing
- Reset values: busy=0, done=0, err=0, awvalid=0, wvalid=0, wlast=0, bready=0, awaddr=0, awlen=0, wdata=0.
- awvalid rises in the cycle after the start edge (registered).
- With no backpressure, each burst takes 1 (AW) + beats (W) + 1 (B, when bvalid returns in the cycle after wlast) cycles plus any slave B latency. The next AW follows in the cycle after the B handshake.
- done pulses in the cycle after the final B handshake. busy falls in that same cycle.
- For word_count=0, done pulses 2 cycles after start.
- All AXI outputs are registered. valid never drops before its ready.

## Test plan
- Single burst:
  - Stimulus: base 0x0000, count 4, pattern 0xA5A5A5A5, incr 0.
  - Required response: one AW with awaddr 0x0000, awlen 3; 4 beats with wlast on beat 4; done pulse; readback of words 0..3 = 0xA5A5A5A5.
- Burst splitting:
  - Stimulus: base 0x0100, count 40, incr 1, pattern 0.
  - Required response: bursts awlen 15/15/7 at awaddr 0x0100/0x0140/0x0180; word at 0x019C = 39.
- 4 KB boundary:
  - Stimulus: base 0x0FF8, count 8.
  - Required response: bursts awlen 1 at 0x0FF8 and awlen 5 at 0x1000.
- Backpressure:
  - Stimulus: awready and wready toggled pseudo-randomly, count 20, incr 1.
  - Required response: no payload change while valid is high and ready is low; RAM holds 0..19; err=0.
- Error response:
  - Stimulus: a slave model returns SLVERR on the 2nd burst of a 3-burst fill.
  - Required response: all 3 bursts complete, then err=1 at done; the next start clears err.
- Zero count and reset:
  - Stimulus: count 0.
  - Required response: done 2 cycles after start, awvalid never high.
  - Stimulus: rst_n pulled low mid-W.
  - Required response: all outputs at reset values immediately; busy=0.
